oam_dma: RTL and testbench
==========================

# oam_dma

Sprite-attribute DMA engine for the video subsystem. A CPU write to the DMA register (0xFF46) with value XX makes the block act as a bus initiator: it copies 160 bytes from XX00–XX9F into OAM at FE00–FE9F, one read plus one write per byte. It sits beside the graphics responder on the system data bus. While a copy is in progress it asserts `busy` so the CPU-side arbiter can stall non-HRAM accesses.

## Interface
Parameters:
- DMA_REG_ADDR, 16'hFF46, CPU-visible trigger/readback register address
- DMA_LEN, 160, bytes per transfer
- DST_BASE, 16'hFE00, OAM base address

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- s_addr  in  16  CPU-side address
- s_wdata  in  8  CPU-side write data
- s_write  in  1  CPU write strobe, one cycle per access
- s_read  in  1  CPU read strobe
- s_hit  out  1  combinational, high when s_addr == DMA_REG_ADDR and (s_read or s_write)
- s_rdata  out  8  dma_reg when s_hit and s_read, else 8'h00
- m_req  out  1  initiator request, held until acknowledged
- m_we  out  1  1 = write, 0 = read; stable while m_req
- m_addr  out  16  initiator address; stable while m_req
- m_wdata  out  8  write data; stable while m_req
- m_rdata  in  8  read data, valid in the cycle m_ack is high on a read
- m_ack  in  1  responder acknowledge, sampled on rising edge
- busy  out  1  high from trigger until final OAM write is acknowledged

## Operation
- Reset values: dma_reg = 8'h00, state IDLE, index 0, m_req 0, m_we 0, m_addr 0, m_wdata 0, busy 0.
- Source high byte: src_hi = XX when XX < 8'hE0, otherwise XX & 8'hDF (echo-RAM fold: E0→C0, FE→DE).
- States:
  - IDLE: s_write hit → dma_reg ← s_wdata, index ← 0, go to START.
  - START: one dead cycle with busy = 1 and m_req = 0; then go to READ.
  - READ: m_req = 1, m_we = 0, m_addr = {src_hi, index}. On m_ack: latch m_rdata, go to WRITE.
  - WRITE: m_req = 1, m_we = 1, m_addr = DST_BASE + index, m_wdata = latched byte. On m_ack: if index == DMA_LEN−1 go to IDLE; else index + 1 and go to READ.
- index is 8 bits; it never exceeds 159, and there is no wrap.
- busy = (state != IDLE).
- m_req is never dropped before m_ack. The responder may stall any number of cycles.
- Reset mid-transfer: abort immediately. OAM keeps whatever bytes were already written.
- A read of dma_reg at any time returns the last value written, not the folded source.

## Timing
- Call the edge that samples the trigger write E0. busy rises after E0. START occupies E0–E1. READ of byte 0 is presented after E1.
- Zero-wait responder (m_ack high in every request cycle): 2 cycles per byte. The last WRITE is acknowledged at E321, and busy falls after E321. busy is high for exactly 321 cycles.
- Each wait cycle inserted by the responder adds exactly one cycle to the total.
- A write to DMA_REG_ADDR in the same cycle as the final acknowledge starts a new transfer: next state is START, not IDLE.

## Configuration
- OAM_DMA_RESTART_EN defined: a trigger write while busy updates dma_reg, discards the in-flight byte, and returns to START with index 0.
  - If a request is outstanding, the abort takes effect only after that request's m_ack. The bus handshake is never broken.
- OAM_DMA_RESTART_EN undefined: trigger writes while busy are ignored. dma_reg is unchanged and the transfer continues.

## Structure
- Add to the video_types package: DMA_REG_ADDR, DMA_LEN and DST_BASE constants (DST_BASE shares OAM_LOC), and the enum dma_state_t {IDLE, START, READ, WRITE}.
- Single module, no sub-module. Address decode, FSM and index counter are too small to split.

## Test plan
- Write 8'hC1 to FF46 with a zero-wait memory model preloaded with C100+i = i^8'h5A → OAM FE00+i == i^8'h5A for i = 0..159; busy high for exactly 321 cycles; s_rdata readback is 8'hC1.
- Trigger 8'hE3 → first m_addr = 16'hC300, last read address 16'hC39F.
- Responder inserts 2 wait cycles on every ack → m_addr/m_we/m_wdata stay stable through every stall; busy is high for 1 + 160×6 = 961 cycles.
- Assert reset at byte 40 during WRITE with m_req high → m_req and busy drop at once; dma_reg = 8'h00; OAM FE28 and above are untouched.
- Second trigger 8'hD0 at byte 10:
  - with OAM_DMA_RESTART_EN: after START, reads begin at D000 and the full 160 bytes come from D0xx;
  - without it: the copy completes from the original source and readback still returns the first value.
- Trigger issued in the same cycle as the final ack → START follows directly and busy never deasserts.

Source files
------------

// File: rtl/oam_dma_pkg.sv
// Shared video-subsystem constants and types for the sprite-attribute DMA engine.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package oam_dma_pkg;

  // OAM window in the system address map
  localparam logic [15:0] OAM_LOC      = 16'hFE00;

  // CPU-visible trigger/readback register
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;

  // Bytes moved per transfer
  localparam int          DMA_LEN      = 160;

  // Destination of every copy is the start of OAM
  localparam logic [15:0] DST_BASE     = OAM_LOC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } dma_state_t;

  // Pages E0..FF mirror C0..DF (echo RAM), so clear bit 5 to reach the real page
  function automatic logic [7:0] fold_src(input logic [7:0] xx);
    return (xx < 8'hE0) ? xx : (xx & 8'hDF);
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA: a write to 0xFF46 copies 160 bytes from {XX,00..9F} into OAM at FE00..FE9F as bus initiator.
// Latency: one dead START cycle, then a read and a write per byte; 321 cycles with a zero-wait responder.
// Backpressure: m_req is held with stable address/data until m_ack; each stall cycle adds one cycle.
// Build option OAM_DMA_RESTART_EN: a trigger while busy restarts the copy (after any outstanding ack);
// without it such triggers are ignored.
module oam_dma
  import oam_dma_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] s_addr,
  input  logic [7:0]  s_wdata,
  input  logic        s_write,
  input  logic        s_read,
  output logic        s_hit,
  output logic [7:0]  s_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [15:0] m_addr,
  output logic [7:0]  m_wdata,
  input  logic [7:0]  m_rdata,
  input  logic        m_ack,
  output logic        busy
);

  dma_state_t state;
  dma_state_t state_nxt;

  logic [7:0] dma_reg;     // last value the CPU wrote, returned on readback
  logic [7:0] src_q;       // folded source page, frozen for the whole copy
  logic [7:0] index;       // byte position within the copy, 0..DMA_LEN-1
  logic [7:0] rbyte;       // byte fetched by READ, replayed by WRITE
  logic       trig;
  logic       last;
  logic       accept;      // this cycle's trigger is taken into dma_reg
  logic       restart_req; // abandon current byte and go back to START

  assign trig  = s_write && (s_addr == DMA_REG_ADDR);
  assign last  = (index == 8'(DMA_LEN - 1));
  assign busy  = (state != IDLE);

  assign s_hit   = (s_addr == DMA_REG_ADDR) && (s_read || s_write);
  assign s_rdata = (s_hit && s_read) ? dma_reg : 8'h00;

`ifdef OAM_DMA_RESTART_EN
  logic restart_pend; // trigger seen while a request was outstanding

  // Remember a mid-request trigger until the responder completes the handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      restart_pend <= 1'b0;
    end else if (state_nxt == START) begin
      restart_pend <= 1'b0;
    end else if (trig && (state == READ || state == WRITE)) begin
      restart_pend <= 1'b1;
    end
  end

  assign restart_req = trig || restart_pend;
  assign accept      = trig;
`else
  assign restart_req = 1'b0;
  assign accept      = trig && ((state == IDLE) || (state == WRITE && m_ack && last));
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: a trigger on the final ack chains straight into a new copy
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (trig) state_nxt = START;
      START: state_nxt = restart_req ? START : READ;
      READ:  if (m_ack) state_nxt = restart_req ? START : WRITE;
      WRITE: begin
        if (m_ack) begin
          if (restart_req || (last && trig)) state_nxt = START;
          else if (last)                     state_nxt = IDLE;
          else                               state_nxt = READ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs decoded from state; idle values are all zero
  always_comb begin
    m_req   = 1'b0;
    m_we    = 1'b0;
    m_addr  = 16'h0000;
    m_wdata = 8'h00;
    unique case (state)
      READ: begin
        m_req  = 1'b1;
        m_addr = {src_q, index};
      end
      WRITE: begin
        m_req   = 1'b1;
        m_we    = 1'b1;
        m_addr  = DST_BASE + {8'h00, index};
        m_wdata = rbyte;
      end
      default: ;
    endcase
  end

  // Trigger register captures accepted CPU writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dma_reg <= 8'h00;
    end else if (accept) begin
      dma_reg <= s_wdata;
    end
  end

  // Source page is frozen on leaving START so m_addr cannot move under a request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q <= 8'h00;
    end else if (state == START && state_nxt == READ) begin
      src_q <= fold_src(dma_reg);
    end
  end

  // Byte index: cleared on every entry to START, advanced after each acked write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index <= 8'h00;
    end else if (state_nxt == START) begin
      index <= 8'h00;
    end else if (state == WRITE && m_ack && state_nxt == READ) begin
      index <= index + 8'd1;
    end
  end

  // Latch the fetched byte on the read acknowledge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rbyte <= 8'h00;
    end else if (state == READ && m_ack) begin
      rbyte <= m_rdata;
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] s_addr = 16'h0000;
  logic [7:0]  s_wdata = 8'h00;
  logic        s_write = 1'b0;
  logic        s_read = 1'b0;
  logic        s_hit;
  logic [7:0]  s_rdata;
  logic        m_req;
  logic        m_we;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata;
  logic [7:0]  m_rdata = 8'h00;
  logic        m_ack = 1'b0;
  logic        busy;

  int total = 0;
  int bad = 0;

  // behavioural system memory and OAM image
  logic [7:0]  mem [0:65535];
  logic [7:0]  oam [0:159];
  logic [15:0] rd_q [$];

  // responder controls / statistics
  int          fixed_wait = 0;
  bit          wait_random = 0;
  bit          hold_en = 0;
  logic [15:0] hold_addr = 16'h0000;
  int          total_waits = 0;
  int          stall_err = 0;
  int          wr_count = 0;
  int          busy_cycles = 0;

  oam_dma dut (
    .clk(clk), .reset(reset),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_write(s_write), .s_read(s_read),
    .s_hit(s_hit), .s_rdata(s_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  // source page as the spec states it: E0..FF are 0x20 below
  function automatic logic [7:0] model_src(input logic [7:0] xx);
    return (xx >= 8'hE0) ? xx - 8'h20 : xx;
  endfunction

  function automatic logic [7:0] model_byte(input logic [7:0] xx, input int i);
    int a;
    a = int'(model_src(xx)) * 256 + i;
    return mem[a];
  endfunction

  // memory responder, acting on the falling edge
  initial begin : responder
    int          wcnt;
    int          cur_wait;
    bit          have_ref;
    logic [15:0] r_addr;
    logic        r_we;
    logic [7:0]  r_wdata;
    wcnt = 0; cur_wait = 0; have_ref = 0;
    r_addr = 16'h0; r_we = 1'b0; r_wdata = 8'h0;
    forever begin
      @(negedge clk);
      if (reset || !m_req) begin
        m_ack = 1'b0; wcnt = 0; have_ref = 0;
      end else begin
        if (!have_ref) begin
          r_addr = m_addr; r_we = m_we; r_wdata = m_wdata; have_ref = 1;
          cur_wait = wait_random ? int'($urandom_range(0, 3)) : fixed_wait;
        end else if (m_addr !== r_addr || m_we !== r_we || m_wdata !== r_wdata) begin
          stall_err++;
        end
        if (hold_en && m_we && m_addr == hold_addr) begin
          m_ack = 1'b0;
        end else if (wcnt < cur_wait) begin
          m_ack = 1'b0; wcnt++; total_waits++;
        end else begin
          m_ack = 1'b1; wcnt = 0; have_ref = 0;
          if (m_we) begin
            wr_count++;
            if (m_addr >= 16'hFE00 && m_addr <= 16'hFE9F) oam[int'(m_addr - 16'hFE00)] = m_wdata;
          end else begin
            m_rdata = mem[m_addr];
            rd_q.push_back(m_addr);
          end
        end
      end
    end
  end

  initial begin : busy_mon
    forever begin
      @(negedge clk);
      if (busy === 1'b1) busy_cycles++;
    end
  end

  task automatic clear_stats(input logic [7:0] fill);
    for (int i = 0; i < 160; i++) oam[i] = fill;
    rd_q.delete();
    total_waits = 0; stall_err = 0; wr_count = 0; busy_cycles = 0;
  endtask

  task automatic randomize_mem();
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    s_addr = a; s_wdata = d; s_write = 1'b1;
    @(negedge clk);
    s_write = 1'b0; s_addr = 16'h0000;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    s_addr = a; s_read = 1'b1;
    #1 d = s_rdata;
    s_read = 1'b0; s_addr = 16'h0000;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    int n;
    n = 0; ok = 1'b0;
    while (n < limit && !ok) begin
      @(negedge clk);
      if (busy === 1'b0) ok = 1'b1;
      n++;
    end
    @(negedge clk);
  endtask

  task automatic check_oam(input string name, input logic [7:0] xx);
    int nbad;
    nbad = 0;
    for (int i = 0; i < 160; i++) begin
      total++;
      if (oam[i] !== model_byte(xx, i)) begin
        bad++; nbad++;
        if (nbad <= 4) $display("FAIL %s oam[%0d] got %h want %h", name, i, oam[i], model_byte(xx, i));
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    #1;
    total++; if (m_req !== 1'b0)      begin bad++; $display("FAIL reset_m_req got %b want 0", m_req); end
    total++; if (m_we !== 1'b0)       begin bad++; $display("FAIL reset_m_we got %b want 0", m_we); end
    total++; if (m_addr !== 16'h0)    begin bad++; $display("FAIL reset_m_addr got %h want 0000", m_addr); end
    total++; if (m_wdata !== 8'h0)    begin bad++; $display("FAIL reset_m_wdata got %h want 00", m_wdata); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    cpu_read(16'hFF46, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_dma_reg got %h want 00", d); end
    s_addr = 16'hFF47; s_read = 1'b1; #1;
    total++; if (s_hit !== 1'b0 || s_rdata !== 8'h00) begin bad++; $display("FAIL miss_decode got hit=%b data=%h want 0/00", s_hit, s_rdata); end
    s_addr = 16'hFF46; #1;
    total++; if (s_hit !== 1'b1) begin bad++; $display("FAIL hit_decode got %b want 1", s_hit); end
    s_read = 1'b0; s_addr = 16'h0000; #1;
    total++; if (s_hit !== 1'b0) begin bad++; $display("FAIL hit_no_strobe got %b want 0", s_hit); end
  endtask

  task automatic test_basic_copy();
    bit ok;
    logic [7:0] d;
    for (int i = 0; i < 160; i++) mem[16'hC100 + i] = 8'(i) ^ 8'h5A;
    fixed_wait = 0; wait_random = 0;
    clear_stats(8'hEE);
    cpu_write(16'hFF46, 8'hC1);
    wait_idle(3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_timeout busy still %b", busy); end
    check_oam("basic", 8'hC1);
    total++; if (busy_cycles != 321) begin bad++; $display("FAIL basic_busy_cycles got %0d want 321", busy_cycles); end
    total++; if (wr_count != 160) begin bad++; $display("FAIL basic_writes got %0d want 160", wr_count); end
    cpu_read(16'hFF46, d);
    total++; if (d !== 8'hC1) begin bad++; $display("FAIL basic_readback got %h want c1", d); end
  endtask

  task automatic test_echo_fold();
    bit ok;
    logic [7:0] d;
    clear_stats(8'hEE);
    cpu_write(16'hFF46, 8'hE3);
    wait_idle(3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL echo_timeout busy still %b", busy); end
    total++; if (rd_q.size() != 160) begin bad++; $display("FAIL echo_reads got %0d want 160", rd_q.size()); end
    if (rd_q.size() > 0) begin
      total++; if (rd_q[0] !== 16'hC300) begin bad++; $display("FAIL echo_first got %h want c300", rd_q[0]); end
      total++; if (rd_q[rd_q.size()-1] !== 16'hC39F) begin bad++; $display("FAIL echo_last got %h want c39f", rd_q[rd_q.size()-1]); end
    end
    check_oam("echo", 8'hE3);
    cpu_read(16'hFF46, d);
    total++; if (d !== 8'hE3) begin bad++; $display("FAIL echo_readback got %h want e3", d); end
  endtask

  task automatic test_wait_states();
    bit ok;
    logic [7:0] xx;
    xx = 8'($urandom_range(0, 255));
    fixed_wait = 2; wait_random = 0;
    clear_stats(8'hEE);
    cpu_write(16'hFF46, xx);
    wait_idle(5000, ok);
    total++; if (!ok) begin bad++; $display("FAIL wait2_timeout busy still %b", busy); end
    total++; if (busy_cycles != 961) begin bad++; $display("FAIL wait2_busy_cycles got %0d want 961", busy_cycles); end
    total++; if (stall_err != 0) begin bad++; $display("FAIL wait2_stable got %0d changes want 0", stall_err); end
    check_oam("wait2", xx);
    // random stall lengths: every wait cycle costs exactly one cycle
    xx = 8'($urandom_range(0, 255));
    fixed_wait = 0; wait_random = 1;
    clear_stats(8'hEE);
    cpu_write(16'hFF46, xx);
    wait_idle(5000, ok);
    wait_random = 0;
    total++; if (!ok) begin bad++; $display("FAIL waitrnd_timeout busy still %b", busy); end
    total++; if (busy_cycles != 321 + total_waits) begin bad++; $display("FAIL waitrnd_busy_cycles got %0d want %0d", busy_cycles, 321 + total_waits); end
    total++; if (stall_err != 0) begin bad++; $display("FAIL waitrnd_stable got %0d changes want 0", stall_err); end
    check_oam("waitrnd", xx);
  endtask

  task automatic test_reset_abort();
    bit found;
    int n;
    int nbad;
    logic [7:0] xx;
    xx = 8'($urandom_range(0, 8'hDF));
    fixed_wait = 0;
    clear_stats(8'hEE);
    hold_en = 1; hold_addr = 16'hFE28;
    cpu_write(16'hFF46, xx);
    found = 0; n = 0;
    while (n < 2000 && !found) begin
      @(negedge clk);
      if (m_req === 1'b1 && m_we === 1'b1 && m_addr === 16'hFE28) found = 1;
      n++;
    end
    total++; if (!found) begin bad++; $display("FAIL abort_reach byte 40 write not seen"); end
    #1 reset = 1'b1;
    #1;
    total++; if (m_req !== 1'b0) begin bad++; $display("FAIL abort_m_req got %b want 0", m_req); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got %b want 0", busy); end
    s_addr = 16'hFF46; s_read = 1'b1; #1;
    total++; if (s_rdata !== 8'h00) begin bad++; $display("FAIL abort_dma_reg got %h want 00", s_rdata); end
    s_read = 1'b0; s_addr = 16'h0000;
    @(negedge clk);
    reset = 1'b0; hold_en = 0;
    repeat (3) @(negedge clk);
    nbad = 0;
    for (int i = 0; i < 160; i++) begin
      logic [7:0] e;
      e = (i < 40) ? model_byte(xx, i) : 8'hEE;
      total++;
      if (oam[i] !== e) begin
        bad++; nbad++;
        if (nbad <= 4) $display("FAIL abort_oam[%0d] got %h want %h", i, oam[i], e);
      end
    end
  endtask

  task automatic test_retrigger();
    bit ok;
    int n;
    int nbad;
    logic [7:0] xx;
    logic [7:0] d;
    xx = 8'($urandom_range(0, 8'hCF));
    fixed_wait = 0;
    clear_stats(8'hEE);
    cpu_write(16'hFF46, xx);
    n = 0;
    while (n < 2000 && rd_q.size() < 11) begin @(negedge clk); n++; end
    cpu_write(16'hFF46, 8'hD0);
    wait_idle(3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL retrig_timeout busy still %b", busy); end
`ifdef OAM_DMA_RESTART_EN
    total++; if (rd_q.size() < 160 || rd_q[rd_q.size()-160] !== 16'hD000) begin bad++; $display("FAIL retrig_restart_start got %0d reads want restart at d000", rd_q.size()); end
    check_oam("retrig", 8'hD0);
    cpu_read(16'hFF46, d);
    total++; if (d !== 8'hD0) begin bad++; $display("FAIL retrig_readback got %h want d0", d); end
`else
    total++; if (busy_cycles != 321) begin bad++; $display("FAIL retrig_busy_cycles got %0d want 321", busy_cycles); end
    nbad = 0;
    for (int i = 0; i < rd_q.size(); i++) if (rd_q[i][15:8] !== model_src(xx)) nbad++;
    total++; if (nbad != 0 || rd_q.size() != 160) begin bad++; $display("FAIL retrig_source got %0d foreign of %0d reads want 0 of 160", nbad, rd_q.size()); end
    check_oam("retrig", xx);
    cpu_read(16'hFF46, d);
    total++; if (d !== xx) begin bad++; $display("FAIL retrig_readback got %h want %h", d, xx); end
`endif
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit found;
    int n;
    logic [7:0] xx;
    logic [7:0] yy;
    logic [7:0] d;
    xx = 8'($urandom_range(0, 255));
    yy = 8'($urandom_range(0, 255));
    fixed_wait = 0;
    clear_stats(8'hEE);
    cpu_write(16'hFF46, xx);
    found = 0; n = 0;
    while (n < 2000 && !found) begin
      @(negedge clk);
      if (m_req === 1'b1 && m_we === 1'b1 && m_addr === 16'hFE9F) found = 1;
      n++;
    end
    total++; if (!found) begin bad++; $display("FAIL b2b_reach final write not seen"); end
    // same cycle as the final acknowledge
    s_addr = 16'hFF46; s_wdata = yy; s_write = 1'b1;
    @(negedge clk);
    s_write = 1'b0; s_addr = 16'h0000;
    wait_idle(3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_timeout busy still %b", busy); end
    total++; if (busy_cycles != 642) begin bad++; $display("FAIL b2b_busy_cycles got %0d want 642", busy_cycles); end
    total++; if (rd_q.size() != 320) begin bad++; $display("FAIL b2b_reads got %0d want 320", rd_q.size()); end
    if (rd_q.size() == 320) begin
      total++; if (rd_q[160] !== {model_src(yy), 8'h00}) begin bad++; $display("FAIL b2b_second_start got %h want %h00", rd_q[160], model_src(yy)); end
    end
    check_oam("b2b", yy);
    cpu_read(16'hFF46, d);
    total++; if (d !== yy) begin bad++; $display("FAIL b2b_readback got %h want %h", d, yy); end
  endtask

  initial begin
    randomize_mem();
    test_reset();
    test_basic_copy();
    test_echo_fold();
    test_wait_states();
    test_reset_abort();
    test_retrigger();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
